// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared register-file constants and the write-request type. Used by the
// write port, the read-side muxes and the writeback stage, so all of them
// agree on register count and field widths.
//   ADDR_W   : register address width
//   DATA_W   : register / write data width
//   NUM_REGS : number of architectural registers
//   ZERO_REG : index of the register that becomes hardwired zero when
//              REGFILE_ZERO_REG_EN is defined
//   wr_req_t : {valid, addr, data} write request
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int ZERO_REG = NUM_REGS - 1;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_port_decoder.sv
// decoder_onehot
// Binary-to-one-hot decoder with enable. With en=0 the output is all zero;
// otherwise exactly the bit selected by sel is set.
//   en     : in  1      decode enable
//   sel    : in  IN_W   binary select
//   onehot : out OUT_W  one-hot result
module decoder_onehot #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 1 << IN_W
) (
    input  logic             en,
    input  logic [IN_W-1:0]  sel,
    output logic [OUT_W-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_write_port.sv
// regfile_write_port
// Stages one register write per cycle and drives the register array's
// one-hot write enables from the staged request. The staged request is also
// compared against both read addresses so the read muxes can forward a write
// that has not yet landed in the array.
//
// Optional feature macro: REGFILE_ZERO_REG_EN
//   When defined, register ZERO_REG is hardwired zero: a write to it still
//   occupies the stage but never raises a write enable or a forwarding hit.
//
// Ports
//   clk, rst_n           : clock, async active-low reset
//   in_valid/addr/data   : incoming write request
//   stall                : hold stage, block capture, suppress array write
//   flush                : drop staged write and current input (beats stall)
//   rd_addr_a, rd_addr_b : read-port addresses for the forwarding compare
//   we                   : one-hot register write enables
//   wdata, fwd_data      : staged write data
//   fwd_a_hit, fwd_b_hit : staged write targets rd_addr_a / rd_addr_b
//   stage_valid          : staged write pending
module regfile_write_port
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [NUM_REGS-1:0] we,
    output logic [DATA_W-1:0]   wdata,
    output logic                fwd_a_hit,
    output logic                fwd_b_hit,
    output logic [DATA_W-1:0]   fwd_data,
    output logic                stage_valid
);

    wr_req_t stage;
    logic    zero_suppress;

    // addr/data are captured even for an invalid request; only valid gates use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else if (flush) begin
            stage.valid <= 1'b0;
        end else if (!stall) begin
            stage <= '{valid: in_valid, addr: in_addr, data: in_data};
        end
    end

`ifdef REGFILE_ZERO_REG_EN
    assign zero_suppress = (stage.addr == ADDR_W'(ZERO_REG));
`else
    assign zero_suppress = 1'b0;
`endif

    decoder_onehot #(
        .IN_W  (ADDR_W),
        .OUT_W (NUM_REGS)
    ) u_we_dec (
        .en     (stage.valid & ~stall & ~zero_suppress),
        .sel    (stage.addr),
        .onehot (we)
    );

    // Hits ignore stall: a stalled write is still the newest value of its register.
    assign fwd_a_hit   = stage.valid & ~zero_suppress & (stage.addr == rd_addr_a);
    assign fwd_b_hit   = stage.valid & ~zero_suppress & (stage.addr == rd_addr_b);
    assign wdata       = stage.data;
    assign fwd_data    = stage.data;
    assign stage_valid = stage.valid;

endmodule

// File: tb/tb_regfile_write_port.sv
module tb_regfile_write_port;
    import regfile_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                in_valid;
    logic [ADDR_W-1:0]   in_addr;
    logic [DATA_W-1:0]   in_data;
    logic                stall;
    logic                flush;
    logic [ADDR_W-1:0]   rd_addr_a;
    logic [ADDR_W-1:0]   rd_addr_b;
    logic [NUM_REGS-1:0] we;
    logic [DATA_W-1:0]   wdata;
    logic                fwd_a_hit;
    logic                fwd_b_hit;
    logic [DATA_W-1:0]   fwd_data;
    logic                stage_valid;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses [NUM_REGS];

    regfile_write_port dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .stall      (stall),
        .flush      (flush),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .we         (we),
        .wdata      (wdata),
        .fwd_a_hit  (fwd_a_hit),
        .fwd_b_hit  (fwd_b_hit),
        .fwd_data   (fwd_data),
        .stage_valid(stage_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the pending write: what the array is still owed.
    bit              m_valid = 1'b0;
    int              m_addr  = 0;
    logic [63:0]     m_data  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_addr  = 0;
            m_data  = '0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_addr  = int'(in_addr);
            m_data  = in_data;
        end
    end

    function automatic bit is_zero_reg(input int a);
`ifdef REGFILE_ZERO_REG_EN
        return a == NUM_REGS - 1;
`else
        return 1'b0;
`endif
    endfunction

    // Per-cycle compare, sampled on the falling edge.
    always @(negedge clk) begin
        logic [63:0] exp_we;
        bit live;
        live   = m_valid && !is_zero_reg(m_addr);
        exp_we = (live && !stall) ? (64'd1 << m_addr) : 64'd0;
        chk("cyc_we", 64'(we), exp_we);
        chk("cyc_wdata", wdata, m_data);
        chk("cyc_fwd_data", fwd_data, m_data);
        chk("cyc_stage_valid", 64'(stage_valid), 64'(m_valid));
        chk("cyc_hit_a", 64'(fwd_a_hit), 64'(live && m_addr == int'(rd_addr_a)));
        chk("cyc_hit_b", 64'(fwd_b_hit), 64'(live && m_addr == int'(rd_addr_b)));
        for (int i = 0; i < NUM_REGS; i++) begin
            if (we[i]) pulses[i]++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic req(input bit v, input int a, input logic [63:0] d);
        in_valid = v;
        in_addr  = ADDR_W'(a);
        in_data  = d;
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) pulses[i] = 0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        req(1, 5, 64'h55);

        // Reset held while a valid request is presented.
        repeat (3) begin
            cyc(); settle();
            chk("rst_we", 64'(we), 64'd0);
            chk("rst_stage_valid", 64'(stage_valid), 64'd0);
            chk("rst_hit_a", 64'(fwd_a_hit), 64'd0);
            chk("rst_wdata", wdata, 64'd0);
        end
        cyc();
        rst_n = 1'b1;
        req(1, 5, 64'hDEAD);
        cyc(); settle();
        chk("first_we", 64'(we), 64'h20);
        chk("first_wdata", wdata, 64'hDEAD);
        req(0, 0, 64'h0);
        cyc(); settle();
        chk("first_we_once", 64'(we), 64'h0);

        // Back-to-back writes.
        req(1, 3, 64'h11);
        cyc(); settle(); chk("b2b_we0", 64'(we), 64'h8);
        req(1, 3, 64'h22);
        cyc(); settle(); chk("b2b_we1", 64'(we), 64'h8); chk("b2b_data1", wdata, 64'h22);
        req(1, 7, 64'h33);
        cyc(); settle(); chk("b2b_we2", 64'(we), 64'h80);
        req(0, 0, 64'h0);
        cyc(); settle(); chk("b2b_idle", 64'(we), 64'h0);

        // Stall holds the staged write; it retires once stall drops.
        rd_addr_a = 5'd10; rd_addr_b = 5'd0;
        req(1, 10, 64'h1234);
        cyc();
        stall = 1'b1;
        req(0, 0, 64'h0);
        repeat (3) begin
            settle();
            chk("stall_we", 64'(we), 64'h0);
            chk("stall_hit_a", 64'(fwd_a_hit), 64'd1);
            chk("stall_data", fwd_data, 64'h1234);
            cyc();
        end
        stall = 1'b0;
        settle();
        chk("unstall_we", 64'(we), 64'h400);
        cyc(); settle();
        chk("unstall_done", 64'(we), 64'h0);
        chk("stall_one_pulse", 64'(pulses[10]), 64'd1);

        // Flush together with stall and a new valid request.
        req(1, 2, 64'h2222);
        cyc();
        flush = 1'b1; stall = 1'b1;
        req(1, 6, 64'h6666);
        settle();
        cyc();
        flush = 1'b0; stall = 1'b0;
        req(0, 0, 64'h0);
        settle();
        chk("flush_stage_valid", 64'(stage_valid), 64'd0);
        chk("flush_we", 64'(we), 64'h0);
        cyc(); settle();
        chk("flush_no_pulse2", 64'(pulses[2]), 64'd0);
        chk("flush_no_pulse6", 64'(pulses[6]), 64'd0);

        // Forwarding compare.
        rd_addr_a = 5'd9; rd_addr_b = 5'd4;
        req(1, 9, 64'hABCD);
        cyc();
        req(0, 0, 64'h0);
        settle();
        chk("fwd_hit_a", 64'(fwd_a_hit), 64'd1);
        chk("fwd_hit_b", 64'(fwd_b_hit), 64'd0);
        chk("fwd_data", fwd_data, 64'hABCD);
        rd_addr_b = 5'd9;
        #1;
        chk("fwd_both_a", 64'(fwd_a_hit), 64'd1);
        chk("fwd_both_b", 64'(fwd_b_hit), 64'd1);

        // Register 31.
        cyc();
        rd_addr_a = 5'd31; rd_addr_b = 5'd31;
        req(1, 31, 64'hFF);
        cyc();
        req(0, 0, 64'h0);
        settle();
        chk("x31_stage_valid", 64'(stage_valid), 64'd1);
`ifdef REGFILE_ZERO_REG_EN
        chk("x31_we", 64'(we), 64'h0);
        chk("x31_hit", 64'(fwd_a_hit), 64'd0);
`else
        chk("x31_we", 64'(we), 64'h8000_0000);
        chk("x31_hit", 64'(fwd_a_hit), 64'd1);
`endif

        // Asynchronous reset during a stall.
        cyc();
        rd_addr_a = 5'd12;
        req(1, 12, 64'hC0DE);
        cyc();
        stall = 1'b1;
        settle();
        chk("midstall_hit", 64'(fwd_a_hit), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_stage_valid", 64'(stage_valid), 64'd0);
        chk("midrst_wdata", wdata, 64'd0);
        chk("midrst_hit", 64'(fwd_a_hit), 64'd0);
        cyc();
        stall = 1'b0;
        req(0, 0, 64'h0);
        rst_n = 1'b1;
        cyc(); settle();
        chk("midrst_no_pulse", 64'(pulses[12]), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
